// File: rtl/muldiv_pkg.sv
// Shared constants for the HI/LO multiply/divide sequencer: op codes, FSM states, default widths.
package muldiv_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 5;

  localparam logic MD_MULTU = 1'b0;
  localparam logic MD_DIVU  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: unsigned shift-add multiply step or restoring divide step.
// acc holds the upper half (accumulator / remainder), lo the lower half (multiplier / quotient).
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] lo_nxt
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;

  always_comb begin
    // Multiply: the carry out of the add lands in acc's MSB after the right shift.
    sum   = {1'b0, acc} + (lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    // Divide: the shifted remainder can need WIDTH+1 bits before the subtract.
    trial = {acc, lo[WIDTH-1]} - {1'b0, operand};
    if (op == MD_MULTU) begin
      acc_nxt = sum[WIDTH:1];
      lo_nxt  = {sum[0], lo[WIDTH-1:1]};
    end else if (!trial[WIDTH]) begin
      acc_nxt = trial[WIDTH-1:0];
      lo_nxt  = {lo[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt = {acc[WIDTH-2:0], lo[WIDTH-1]};
      lo_nxt  = {lo[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/muldiv_seq.sv
// HI/LO sequencer: 32-cycle MULTU/DIVU, single HI/LO write strobe on completion,
// and pipeline stall for MFHI/MFLO or a new mul/div while an operation is in flight.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hilo_req,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             hilo_we,
  output logic [WIDTH-1:0] hi_wdata,
  output logic [WIDTH-1:0] lo_wdata
);
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] lo_nxt;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op      (op_q),
    .acc     (acc),
    .lo      (lo_q),
    .operand (operand),
    .acc_nxt (acc_nxt),
    .lo_nxt  (lo_nxt)
  );

  assign busy    = (state != S_IDLE);
  assign stall   = busy & (hilo_req | start) & ~flush;
  // A flush landing on the DONE cycle must suppress the write.
  assign hilo_we = (state == S_DONE) & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= MD_MULTU;
      acc      <= '0;
      lo_q     <= '0;
      operand  <= '0;
      hi_wdata <= '0;
      lo_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !flush) begin
            op_q <= op;
            acc  <= '0;
            cnt  <= CNT_W'(WIDTH - 1);
            if (op == MD_DIVU && src_b == '0) begin
              hi_wdata <= src_a;
              lo_wdata <= '1;
              state    <= S_DONE;
            end else begin
              // Multiply: src_b is the shifting multiplier; divide: src_a is the dividend.
              lo_q    <= (op == MD_MULTU) ? src_b : src_a;
              operand <= (op == MD_MULTU) ? src_a : src_b;
              state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc  <= acc_nxt;
            lo_q <= lo_nxt;
            if (cnt == '0) begin
              hi_wdata <= acc_nxt;
              lo_wdata <= lo_nxt;
              state    <= S_DONE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Directed-vector bench for muldiv_seq with hand-computed HI/LO results and cycle timing.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hilo_req;
  logic        flush;
  logic        busy;
  logic        stall;
  logic        hilo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .hilo_req (hilo_req),
    .flush    (flush),
    .busy     (busy),
    .stall    (stall),
    .hilo_we  (hilo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present start during cycle T; returns positioned in cycle T+1.
  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    tick();
    start = 1'b0;
  endtask

  // Watch ncyc cycles starting at the current one; first is the offset of the first strobe.
  task automatic watch(input int ncyc, output int pulses, output int first,
                       output logic [31:0] hi, output logic [31:0] lo);
    pulses = 0;
    first  = -1;
    hi     = '0;
    lo     = '0;
    for (int k = 0; k < ncyc; k++) begin
      if (hilo_we) begin
        if (pulses == 0) begin
          first = k;
          hi    = hi_wdata;
          lo    = lo_wdata;
        end
        pulses++;
      end
      tick();
    end
  endtask

  task automatic run_op(input string tag, input logic o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int p, f;
    logic [31:0] h, l;
    issue(o, a, b);
    watch(36, p, f, h, l);
    check_eq({tag, "_pulses"}, p, 1);
    check_eq({tag, "_when"}, f, 32);
    check_eq({tag, "_hi"}, h, exp_hi);
    check_eq({tag, "_lo"}, l, exp_lo);
  endtask

  initial begin
    int p, f;
    logic [31:0] h, l;

    rst = 1'b1; start = 1'b0; op = MD_MULTU; src_a = '0; src_b = '0;
    hilo_req = 1'b0; flush = 1'b0;
    tick();
    tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_we", hilo_we, 0);
    check_eq("rst_hi", hi_wdata, 0);
    check_eq("rst_lo", lo_wdata, 0);
    check_eq("rst_stall", stall, 0);
    rst = 1'b0;
    tick();

    // MULTU max*max: busy T+1..T+33, single strobe at T+33.
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int n = 1; n <= 34; n++) begin
      check_eq($sformatf("mul_busy_%0d", n), busy, (n <= 33) ? 1 : 0);
      check_eq($sformatf("mul_we_%0d", n), hilo_we, (n == 33) ? 1 : 0);
      if (n == 33) begin
        check_eq("mul_max_hi", hi_wdata, 32'hFFFF_FFFE);
        check_eq("mul_max_lo", lo_wdata, 32'h0000_0001);
      end
      tick();
    end

    run_op("div_100_7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_5_9", MD_DIVU, 32'd5, 32'd9, 32'd5, 32'd0);
    run_op("div_big", MD_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'd1);
    run_op("mul_mix", MD_MULTU, 32'h0001_0000, 32'h0003_0005, 32'h0000_0003, 32'h0005_0000);

    // Divide by zero skips the iterations entirely.
    issue(MD_DIVU, 32'h1234, 32'd0);
    watch(6, p, f, h, l);
    check_eq("div0_pulses", p, 1);
    check_eq("div0_early", (f >= 0 && f <= 1) ? 1 : 0, 1);
    check_eq("div0_hi", h, 32'h1234);
    check_eq("div0_lo", l, 32'hFFFF_FFFF);

    // Simultaneous start + hilo_req in IDLE does not stall; MFHI then waits through DONE.
    start = 1'b1; op = MD_MULTU; src_a = 32'd3; src_b = 32'd4; hilo_req = 1'b1;
    #1;
    check_eq("idle_start_req_stall", stall, 0);
    tick();
    start = 1'b0;
    for (int n = 1; n <= 34; n++) begin
      check_eq($sformatf("stall_%0d", n), stall, (n <= 33) ? 1 : 0);
      if (n == 20) begin
        flush = 1'b1;
        #1;
        check_eq("flush_kills_stall", stall, 0);
        flush = 1'b0;
        #1;
      end
      if (n != 34) tick();
    end
    hilo_req = 1'b0;
    check_eq("mul34_hi", hi_wdata, 32'd0);
    check_eq("mul34_lo", lo_wdata, 32'd12);
    tick();

    // Flush mid-multiply: no write, unit idle next cycle.
    issue(MD_MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
    for (int k = 1; k < 10; k++) begin
      if (hilo_we) check_eq("flush_pre_we", hilo_we, 0);
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush_busy", busy, 0);
    watch(30, p, f, h, l);
    check_eq("flush_pulses", p, 0);
    check_eq("flush_keep_lo", lo_wdata, 32'd12);
    run_op("div_9_3", MD_DIVU, 32'd9, 32'd3, 32'd0, 32'd3);

    // Reset mid-divide: outputs cleared, no write.
    issue(MD_DIVU, 32'd100, 32'd7);
    for (int k = 1; k < 20; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_we", hilo_we, 0);
    check_eq("midrst_hi", hi_wdata, 0);
    check_eq("midrst_lo", lo_wdata, 0);
    watch(30, p, f, h, l);
    check_eq("midrst_pulses", p, 0);

    // Start while busy is ignored; exactly one strobe from the original divide.
    issue(MD_DIVU, 32'd100, 32'd7);
    for (int k = 1; k < 5; k++) tick();
    start = 1'b1; op = MD_MULTU; src_a = 32'd2; src_b = 32'd2;
    #1;
    check_eq("busy_start_stall", stall, 1);
    tick();
    start = 1'b0;
    watch(40, p, f, h, l);
    check_eq("busy_start_pulses", p, 1);
    check_eq("busy_start_when", f, 27);
    check_eq("busy_start_hi", h, 32'd2);
    check_eq("busy_start_lo", l, 32'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
